// File: rtl/mul_tree_out_collector.sv
`default_nettype none
// ============================================================================
// Module  : mul_tree_out_collector
// Brief   : Aligns bf16 multiplier-tree lane strobes into groups and queues
//           them in a small FIFO for the writeback stage.
// Rev     : 1.0  initial release
// ============================================================================
module mul_tree_out_collector #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [4*DW-1:0]        lane_data,
    input  logic [3:0]             lane_stb,
    output logic [4*DW-1:0]        out_data,
    output logic [3:0]             out_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   ovf_err,
    output logic                   drop_err
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam int              GW      = 4 * DW;
    localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

    logic [1:0]    mode_q, mode_d;
    logic [GW-1:0] hold_q, hold_d;
    logic [3:0]    hold_v_q, hold_v_d;
    logic [GW-1:0] fifo_data_q [DEPTH];
    logic [GW-1:0] fifo_data_d [DEPTH];
    logic [3:0]    fifo_mask_q [DEPTH];
    logic [3:0]    fifo_mask_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_err_q, ovf_err_d;
    logic          drop_err_q, drop_err_d;

    logic [3:0]    lane_mask;
    logic [3:0]    capture;
    logic [GW-1:0] group_data;
    logic          complete;
    logic          push;
    logic          pop;

    always_comb begin
        case (mode_q)
            2'd1:    lane_mask = 4'b0101;
            2'd2:    lane_mask = 4'b0001;
            default: lane_mask = 4'b1111;
        endcase

        complete = ((hold_v_q & lane_mask) == lane_mask);
        pop      = (count_q != '0) && out_ready;
        push     = complete && ((count_q < C_DEPTH) || pop);

        // A lane being pushed this edge frees its hold register for a new strobe.
        capture  = lane_stb & lane_mask & (~hold_v_q | {4{push}});
        hold_v_d = capture | (hold_v_q & ~(lane_mask & {4{push}}));

        hold_d     = hold_q;
        group_data = '0;
        for (int k = 0; k < 4; k++) begin
            if (lane_mask[k]) begin
                group_data[k*DW +: DW] = hold_q[k*DW +: DW];
            end
            if (capture[k]) begin
                hold_d[k*DW +: DW] = lane_data[k*DW +: DW];
            end
        end

        // Mode only switches between groups so a partial group keeps its mask.
        mode_d     = (hold_v_q == 4'b0000) ? mode : mode_q;
        ovf_err_d  = ovf_err_q | (|(lane_stb & lane_mask & hold_v_q & ~{4{push}}));
        drop_err_d = drop_err_q | (complete & ~push);

        fifo_data_d = fifo_data_q;
        fifo_mask_d = fifo_mask_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = group_data;
            fifo_mask_d[wr_ptr_q] = lane_mask;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q     <= 2'd0;
            hold_q     <= '0;
            hold_v_q   <= 4'b0000;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_err_q  <= 1'b0;
            drop_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_mask_q[i] <= 4'b0000;
            end
        end else begin
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            hold_v_q    <= hold_v_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_err_q   <= ovf_err_d;
            drop_err_q  <= drop_err_d;
            fifo_data_q <= fifo_data_d;
            fifo_mask_q <= fifo_mask_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_mask   = out_valid ? fifo_mask_q[rd_ptr_q] : 4'b0000;
    assign fifo_count = count_q;
    assign ovf_err    = ovf_err_q;
    assign drop_err   = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_tree_out_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_tree_out_collector
// Brief   : Directed scenarios plus random traffic against a queue-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mul_tree_out_collector;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic [1:0]  mode      = 2'd0;
    logic [63:0] lane_data = 64'h0;
    logic [3:0]  lane_stb  = 4'h0;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [3:0]  out_mask;
    logic        out_valid;
    logic [2:0]  fifo_count;
    logic        ovf_err;
    logic        drop_err;

    int total  = 0;
    int passed = 0;

    mul_tree_out_collector #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .lane_data  (lane_data),
        .lane_stb   (lane_stb),
        .out_data   (out_data),
        .out_mask   (out_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .ovf_err    (ovf_err),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    // Reference model: groups as queue entries {mask, data}, lanes as slots.
    logic [1:0]  m_mode = 2'd0;
    logic [15:0] m_hold [4];
    bit   [3:0]  m_hv   = 4'h0;
    logic [67:0] m_q [$];
    bit          m_ovf  = 1'b0;
    bit          m_drop = 1'b0;

    function automatic logic [3:0] lanes_of(input logic [1:0] md);
        case (md)
            2'd1:    return 4'b0101;
            2'd2:    return 4'b0001;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0]  msk;
        logic [67:0] grp;
        bit          ready_grp, busy, do_pop, do_push;
        if (!rst) begin
            m_mode = 2'd0;
            m_hv   = 4'h0;
            m_q.delete();
            m_ovf  = 1'b0;
            m_drop = 1'b0;
        end else begin
            msk       = lanes_of(m_mode);
            ready_grp = 1'b1;
            for (int k = 0; k < 4; k++) if (msk[k] && !m_hv[k]) ready_grp = 1'b0;
            busy      = (m_hv != 4'h0);
            do_pop    = (m_q.size() != 0) && out_ready;
            do_push   = ready_grp && ((m_q.size() < DEPTH) || do_pop);
            if (ready_grp && !do_push) m_drop = 1'b1;
            grp = {msk, 64'h0};
            for (int k = 0; k < 4; k++) if (msk[k]) grp[k*16 +: 16] = m_hold[k];
            if (do_push) m_hv = m_hv & ~msk;
            for (int k = 0; k < 4; k++) begin
                if (lane_stb[k] && msk[k]) begin
                    if (m_hv[k]) m_ovf = 1'b1;
                    else begin
                        m_hold[k] = lane_data[k*16 +: 16];
                        m_hv[k]   = 1'b1;
                    end
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(grp);
            if (!busy) m_mode = mode;
        end
    endtask

    // Every clock advance goes through here so the model sees each edge once.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] stb, input logic [63:0] d);
        lane_stb  = stb;
        lane_data = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(4'h0, 64'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'($urandom), {$urandom, $urandom});
            tick();
            total++;
            if ({out_valid, out_mask, out_data, fifo_count, ovf_err, drop_err} !== 74'h0)
                $display("FAIL reset_outputs: got valid=%0b mask=%h data=%h count=%0d ovf=%0b drop=%0b want all 0",
                         out_valid, out_mask, out_data, fifo_count, ovf_err, drop_err);
            else passed++;
        end
        rst = 1'b1;
        drive(4'h0, 64'h0);
        repeat (4) tick();
        total++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL idle_after_reset: got valid=%0b count=%0d want 0/0", out_valid, fifo_count);
        else passed++;
    endtask

    task automatic test_mode0_staggered();
        mode = 2'd0; out_ready = 1'b0;
        do_reset();
        drive(4'b0001, 64'h0000_0000_0000_3F80); tick();
        drive(4'b0010, 64'h0000_0000_4000_0000); tick();
        drive(4'b0000, 64'h0);                   tick();
        drive(4'b1100, 64'h4080_4040_0000_0000); tick();
        drive(4'b0000, 64'h0);
        total++;
        if (out_valid !== 1'b0) $display("FAIL stag_early_valid: got %0b want 0", out_valid);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1) $display("FAIL stag_valid: got %0b want 1", out_valid);
        else passed++;
        total++;
        if (out_data !== 64'h4080_4040_4000_3F80 || out_mask !== 4'hF)
            $display("FAIL stag_group: got data=%h mask=%h want 4080404040003f80/f", out_data, out_mask);
        else passed++;
        tick();
        total++;
        if (out_data !== 64'h4080_4040_4000_3F80 || fifo_count !== 3'd1)
            $display("FAIL stag_hold_stable: got data=%h count=%0d want 4080404040003f80/1", out_data, fifo_count);
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL stag_pop: got valid=%0b count=%0d want 0/0", out_valid, fifo_count);
        else passed++;
    endtask

    task automatic test_mode1();
        mode = 2'd1; out_ready = 1'b0;
        do_reset();
        drive(4'b1111, 64'h4444_3333_2222_1111); tick();
        drive(4'b0000, 64'h0);                   tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 64'h0000_3333_0000_1111 || out_mask !== 4'h5)
            $display("FAIL mode1_group: got valid=%0b data=%h mask=%h want 1/0000333300001111/5",
                     out_valid, out_data, out_mask);
        else passed++;
        total++;
        if (ovf_err !== 1'b0 || fifo_count !== 3'd1)
            $display("FAIL mode1_ovf: got ovf=%0b count=%0d want 0/1", ovf_err, fifo_count);
        else passed++;
    endtask

    task automatic test_backpressure();
        int exp_v = 1;
        mode = 2'd2; out_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            drive(4'b0001, 64'(i));
            tick();
        end
        total++;
        if (fifo_count !== 3'd4 || drop_err !== 1'b1)
            $display("FAIL bp_full: got count=%0d drop=%0b want 4/1", fifo_count, drop_err);
        else passed++;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                total++;
                if (out_data !== 64'(exp_v) || out_mask !== 4'h1)
                    $display("FAIL bp_order: got data=%h mask=%h want %h/1", out_data, out_mask, 64'(exp_v));
                else passed++;
                exp_v++;
            end
            if (i == 0) out_ready = 1'b1;
            if (i == 1) drive(4'b0000, 64'h0);
            tick();
        end
        total++;
        if (exp_v !== 7) $display("FAIL bp_count: got %0d groups want 6", exp_v - 1);
        else passed++;
    endtask

    task automatic test_overflow();
        mode = 2'd0; out_ready = 1'b0;
        do_reset();
        drive(4'b0100, 64'h0000_AAAA_0000_0000); tick();
        drive(4'b0100, 64'h0000_BBBB_0000_0000); tick();
        drive(4'b1011, 64'h0003_0000_0002_0001); tick();
        drive(4'b0000, 64'h0);                   tick();
        total++;
        if (ovf_err !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", ovf_err);
        else passed++;
        total++;
        if (out_valid !== 1'b1 || out_data !== 64'h0003_AAAA_0002_0001)
            $display("FAIL ovf_group: got valid=%0b data=%h want 1/0003aaaa00020001", out_valid, out_data);
        else passed++;
    endtask

    task automatic test_throughput_reset();
        logic [63:0] expq [$];
        int got  = 0;
        int gaps = 0;
        bit started = 1'b0;
        mode = 2'd0; out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            if (out_valid) begin
                started = 1'b1;
                total++;
                if (expq.size() == 0 || out_data !== expq[0])
                    $display("FAIL tput_data: group %0d got %h want %h", got, out_data,
                             (expq.size() != 0) ? expq[0] : 64'h0);
                else passed++;
                if (expq.size() != 0) void'(expq.pop_front());
                got++;
            end else if (started && got < 16) gaps++;
            if (c < 16) begin
                drive(4'hF, {$urandom, $urandom});
                expq.push_back(lane_data);
            end else drive(4'h0, 64'h0);
            tick();
        end
        total++;
        if (got !== 16 || gaps !== 0)
            $display("FAIL tput_stream: got groups=%0d gaps=%0d want 16/0", got, gaps);
        else passed++;
        for (int c = 0; c < 6; c++) begin
            drive(4'hF, {$urandom, $urandom});
            tick();
        end
        rst = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL tput_reset: got valid=%0b count=%0d want 0/0", out_valid, fifo_count);
        else passed++;
        rst = 1'b1;
        drive(4'h0, 64'h0);
        repeat (4) tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL tput_no_stale: got valid=%0b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            drive(4'($urandom), {$urandom, $urandom});
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            total++;
            if (out_valid !== (m_q.size() != 0) || fifo_count !== 3'(m_q.size()))
                $display("FAIL rand_level: cyc %0d got valid=%0b count=%0d want %0b/%0d",
                         c, out_valid, fifo_count, m_q.size() != 0, m_q.size());
            else passed++;
            total++;
            if (ovf_err !== m_ovf || drop_err !== m_drop)
                $display("FAIL rand_err: cyc %0d got ovf=%0b drop=%0b want %0b/%0b",
                         c, ovf_err, drop_err, m_ovf, m_drop);
            else passed++;
            if (m_q.size() != 0) begin
                total++;
                if (out_data !== m_q[0][63:0] || out_mask !== m_q[0][67:64])
                    $display("FAIL rand_head: cyc %0d got data=%h mask=%h want %h/%h",
                             c, out_data, out_mask, m_q[0][63:0], m_q[0][67:64]);
                else passed++;
            end
        end
        rst = 1'b1;
        drive(4'h0, 64'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode0_staggered();
        test_mode1();
        test_backpressure();
        test_overflow();
        test_throughput_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_tree_out_collector.md
Name: mul_tree_out_collector

Overview:
- Sits directly downstream of the bf16 multiplier tree.
- Consumes the tree's packed lane results and the per-lane output strobes, which can fire on different cycles depending on mode.
- Aligns all lanes expected for the current mode into one result group and buffers groups in a small FIFO.
- Presents groups on a valid/ready interface to the writeback stage.

Parameters:
- DW, 16, width of one lane result (bf16).
- DEPTH, 4, FIFO depth in groups; power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (active when 0).
- mode  in  2  tree mode; selects expected lanes.
- lane_data  in  4*DW  packed tree outputs; lane k = bits [k*DW +: DW].
- lane_stb  in  4  per-lane result strobe from the tree.
- out_data  out  4*DW  group data; lanes not in the mask read 0.
- out_mask  out  4  lane mask of the group being presented.
- out_valid  out  1  group available.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- fifo_count  out  $clog2(DEPTH)+1  groups currently buffered.
- ovf_err  out  1  sticky: a lane strobed while its hold register was still full.
- drop_err  out  1  sticky: a group completed while the FIFO was full and no pop occurred.

Behaviour:
- Reset (rst==0 at a clock edge):
  - out_data=0, out_mask=0, out_valid=0, fifo_count=0, ovf_err=0, drop_err=0.
  - All hold valid flags cleared; FIFO pointers at 0; mode_q=0.
  - Reset mid-group discards partial lanes and all buffered groups.
- Mask decode from mode_q:
  - 0 -> 4'b1111
  - 1 -> 4'b0101
  - 2 -> 4'b0001
  - 3 (reserved) -> 4'b1111
- Mode latch: mode_q <= mode only on edges where no hold flag is set. A mode change while a group is partially captured takes effect after that group is pushed.
- Lane capture, per lane k, at an edge with lane_stb[k]=1:
  - mask[k]=0: ignored.
  - hold_v[k]=0, or the group is being pushed this cycle: capture lane_data into hold[k] and set hold_v[k].
  - Otherwise: ovf_err<=1, new value dropped, held value kept.
- Group complete: (hold_v & mask) == mask, evaluated combinationally from registered state.
- Push condition: complete & (fifo_count<DEPTH | pop).
  - On push: write {mask-gated hold data, mask} into the FIFO.
  - Clear hold_v for masked lanes, except lanes recaptured the same edge, which stay set with the new data.
- Complete with FIFO full and no pop: drop_err<=1. The group is held (not discarded), and the push is retried every cycle.
- Pop: out_valid & out_ready.
  - Push and pop in the same cycle at count=DEPTH is legal; count stays DEPTH.
  - Pop at count=0 cannot occur because out_valid=0.
- out_valid = (fifo_count!=0). out_data and out_mask come from the FIFO head register and are stable while out_valid & !out_ready.
- Pointer wrap: DEPTH is a power of 2, so pointers wrap modulo DEPTH naturally. fifo_count tracks full vs empty.
- Latency: last required lane strobe at edge t -> push at edge t+1 -> out_valid=1 after edge t+1 when the FIFO was empty, i.e. 2 cycles from strobe to valid.
- Throughput: one group per cycle sustained when all masked strobes arrive each cycle and out_ready=1.
- Error flags are cleared only by reset.

Test Plan:
- Reset/idle: hold rst=0 for 5 cycles with random lane_stb -> all outputs 0. Release; no strobes -> out_valid stays 0 and fifo_count=0.
- Mode 0 staggered lanes:
  - Stimulus: lane 0=16'h3F80 @t, lane 1=16'h4000 @t+1, lane 2=16'h4040 and lane 3=16'h4080 @t+3.
  - Required: out_valid rises after edge t+4, out_data=64'h4080_4040_4000_3F80, out_mask=4'hF.
- Mode 1: strobe all 4 lanes with 16'h1111/2222/3333/4444 -> out_data=64'h0000_3333_0000_1111, out_mask=4'h5. Lanes 1 and 3 ignored, ovf_err=0.
- Backpressure:
  - Stimulus: mode 2, out_ready=0, 6 single-lane groups 16'h0001..16'h0006.
  - Required: fifo_count=4, drop_err=1, group 5 still held.
  - Then set out_ready=1: groups pop in order 1..5, and 6 is captured once lane 0's hold is freed.
- Overflow: mode 0, lane 2 strobed twice (16'hAAAA then 16'hBBBB) before the other lanes arrive -> ovf_err=1, group carries 16'hAAAA in lane 2.
- Full-throughput plus reset: mode 0, all strobes every cycle for 16 cycles, out_ready=1 -> 16 groups, in order, no gaps after the first. Assert rst=0 mid-stream -> next cycle out_valid=0, fifo_count=0.
